reg_wb_arbiter: RTL and testbench
=================================

Name: reg_wb_arbiter

Overview:
- Writeback stage directly upstream of the register file's write port (port B).
- Merges results from two producers, the ALU and the load unit, onto the single write port, one write per cycle.
- Each producer has a one-entry holding register.
- Exposes a forwarding lookup so decode can read results that are still pending and not yet in the register file.

Parameters:
- DATA_W, 32, data width of results and write port.
- ADDR_W, 5, register address width (32 registers).
- STARVE_LIMIT, 4, consecutive cycles an ALU entry may lose arbitration before it is forced through.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- alu_valid  in  1  ALU result offered.
- alu_ready  out  1  ALU hold can accept.
- alu_addr  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- ld_valid  in  1  load result offered.
- ld_ready  out  1  load hold can accept.
- ld_addr  in  ADDR_W  load destination register.
- ld_data  in  DATA_W  load result.
- wb_we  out  1  write enable to register file port B (web).
- wb_addr  out  ADDR_W  write address (addrb).
- wb_data  out  DATA_W  write data (dinb).
- fwd_addr  in  ADDR_W  forwarding lookup address.
- fwd_hit  out  1  a pending or in-flight write targets fwd_addr.
- fwd_data  out  DATA_W  youngest pending value for fwd_addr.

Behaviour:
- Reset (async, any cycle, including mid-transfer):
  - Both holds invalid; in-flight entries are discarded.
  - wb_we=0, wb_addr=0, wb_data=0.
  - Starve counter=0, order flag=0.
  - alu_ready=ld_ready=0 while rst is high.
  - fwd_hit=0.
- Holds: each source has a one-entry register (v, addr, data).
  - X_ready = ~rst & (~X_v | X granted this cycle).
  - Transfer occurs when X_valid & X_ready at the rising edge.
- Address 0:
  - The transfer handshakes normally, but the entry is dropped and the hold stays empty.
  - wb_we is never asserted with wb_addr=0.
- Arbitration (combinational, on hold state each cycle):
  - Only one hold valid: grant it.
  - Both valid, same addr: grant the older entry.
    - Order flag records which hold was filled first.
    - If both were filled at the same edge, ALU is older (it issued earlier in program order).
  - Both valid, different addr:
    - Grant load, unless starve counter == STARVE_LIMIT-1; then grant ALU.
- Starve counter:
  - Increments when the ALU hold is valid and not granted.
  - Clears when ALU is granted or the ALU hold is empty.
  - Saturates at STARVE_LIMIT-1.
- Output stage (registered):
  - Granted entry is loaded into wb_we/wb_addr/wb_data at the next edge.
  - wb_we=0 when nothing is granted; wb_addr/wb_data hold their last values.
  - Latency: accept at edge N → granted at the earliest in cycle N+1 → wb_we high after edge N+1 for one cycle.
- Throughput:
  - One write per cycle.
  - A granted hold may refill at the same edge (back-to-back).
- Forwarding (combinational):
  - Compares fwd_addr against the output stage (wb_we), the ALU hold, and the load hold.
  - Priority youngest-first: of the two holds, the younger per the order flag; then the output stage.
  - fwd_addr=0 → fwd_hit=0.
  - fwd_data is don't-care when fwd_hit=0 but must be driven (0).

Test Plan:
- Reset then single ALU write (addr 3, data 0xDEADBEEF) → wb_we=1, wb_addr=3, wb_data=0xDEADBEEF exactly one cycle after the accept edge; wb_we=0 the next cycle.
- Same-edge ALU (r5=0x11) and load (r6=0x22) → load written first, ALU the following cycle; alu_ready low in between.
- Load stream every cycle to r7..r14 with ALU r2 pending, STARVE_LIMIT=4 → ALU written on the 4th cycle after it becomes valid; load stalls (ld_ready=0) for that cycle only.
- ALU r9=0x1 accepted, then load r9=0x2 one cycle later with a load backlog → r9 written 0x1 then 0x2; fwd_addr=9 returns 0x2 while the load is pending.
- Write to addr 0 (data 0xFFFF) → handshake completes, wb_we stays 0, fwd_hit=0 for fwd_addr=0.
- Assert rst mid-stream with both holds full → wb_we drops immediately, readies=0; after release no stale write appears and readies=1.

Source files
------------

// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - producer, register-file write port and forwarding bundle for reg_wb_arbiter
// The master side is the producers plus decode; the slave side is the arbiter.

interface reg_wb_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;

    logic              wb_we;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;

    logic [ADDR_W-1:0] fwd_addr;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output ld_valid, ld_addr, ld_data,
        output fwd_addr,
        input  alu_ready, ld_ready,
        input  wb_we, wb_addr, wb_data,
        input  fwd_hit, fwd_data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  ld_valid, ld_addr, ld_data,
        input  fwd_addr,
        output alu_ready, ld_ready,
        output wb_we, wb_addr, wb_data,
        output fwd_hit, fwd_data
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - merges ALU and load results onto register file port B
// One-entry hold per producer, age/starvation arbitration, registered write stage, forwarding lookup.

module reg_wb_arbiter #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    reg_wb_arbiter_if.slave   bus
);
    localparam int CNT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT) : 1;
    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT - 1);

    // Which hold was filled first; only meaningful while both holds are valid.
    typedef enum logic {
        ALU_OLDER = 1'b0,
        LD_OLDER  = 1'b1
    } order_t;

    order_t            order_q;
    order_t            order_d;

    logic              alu_v;
    logic [ADDR_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_d;
    logic              ld_v;
    logic [ADDR_W-1:0] ld_a;
    logic [DATA_W-1:0] ld_d;

    logic [CNT_W-1:0]  starve_q;
    logic [CNT_W-1:0]  starve_d;

    logic              gnt_alu;
    logic              gnt_ld;
    logic              alu_fire;
    logic              ld_fire;
    logic              alu_fill;
    logic              ld_fill;
    logic              alu_keep;
    logic              ld_keep;

    logic              wb_we_q;
    logic [ADDR_W-1:0] wb_addr_q;
    logic [DATA_W-1:0] wb_data_q;

    logic              fwd_hit_c;
    logic [DATA_W-1:0] fwd_data_c;
    logic              alu_match;
    logic              ld_match;
    logic              out_match;

    always_comb begin
        gnt_alu = 1'b0;
        gnt_ld  = 1'b0;
        if (alu_v && ld_v) begin
            if (alu_a == ld_a) begin
                if (order_q == ALU_OLDER) gnt_alu = 1'b1;
                else                      gnt_ld  = 1'b1;
            end else if (starve_q == STARVE_MAX) begin
                gnt_alu = 1'b1;
            end else begin
                gnt_ld = 1'b1;
            end
        end else begin
            gnt_alu = alu_v;
            gnt_ld  = ld_v;
        end
    end

    assign bus.alu_ready = ~rst & (~alu_v | gnt_alu);
    assign bus.ld_ready  = ~rst & (~ld_v  | gnt_ld);

    assign alu_fire = bus.alu_valid & bus.alu_ready;
    assign ld_fire  = bus.ld_valid  & bus.ld_ready;
    // Writes to r0 complete the handshake but never occupy a hold.
    assign alu_fill = alu_fire & (bus.alu_addr != '0);
    assign ld_fill  = ld_fire  & (bus.ld_addr  != '0);
    assign alu_keep = alu_v & ~gnt_alu;
    assign ld_keep  = ld_v  & ~gnt_ld;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_v <= 1'b0;
            alu_a <= '0;
            alu_d <= '0;
        end else if (alu_fire) begin
            alu_v <= alu_fill;
            alu_a <= bus.alu_addr;
            alu_d <= bus.alu_data;
        end else if (gnt_alu) begin
            alu_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ld_v <= 1'b0;
            ld_a <= '0;
            ld_d <= '0;
        end else if (ld_fire) begin
            ld_v <= ld_fill;
            ld_a <= bus.ld_addr;
            ld_d <= bus.ld_data;
        end else if (gnt_ld) begin
            ld_v <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) order_q <= ALU_OLDER;
        else     order_q <= order_d;
    end

    // A surviving entry is older than anything filled beside it; simultaneous fills favour the ALU.
    always_comb begin
        order_d = order_q;
        if (alu_keep && !ld_keep)       order_d = ALU_OLDER;
        else if (ld_keep && !alu_keep)  order_d = LD_OLDER;
        else if (!alu_keep && !ld_keep) order_d = ALU_OLDER;
    end

    always_comb begin
        starve_d = '0;
        if (alu_keep) begin
            starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) starve_q <= '0;
        else     starve_q <= starve_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_we_q <= gnt_alu | gnt_ld;
            if (gnt_alu) begin
                wb_addr_q <= alu_a;
                wb_data_q <= alu_d;
            end else if (gnt_ld) begin
                wb_addr_q <= ld_a;
                wb_data_q <= ld_d;
            end
        end
    end

    assign bus.wb_we   = wb_we_q;
    assign bus.wb_addr = wb_addr_q;
    assign bus.wb_data = wb_data_q;

    assign alu_match = alu_v   && (alu_a     == bus.fwd_addr);
    assign ld_match  = ld_v    && (ld_a      == bus.fwd_addr);
    assign out_match = wb_we_q && (wb_addr_q == bus.fwd_addr);

    // Youngest value wins: younger hold, then older hold, then the write stage.
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        if (!rst && (bus.fwd_addr != '0)) begin
            if (alu_match && ld_match) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = (order_q == ALU_OLDER) ? ld_d : alu_d;
            end else if (alu_match) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = alu_d;
            end else if (ld_match) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = ld_d;
            end else if (out_match) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = wb_data_q;
            end
        end
    end

    assign bus.fwd_hit  = fwd_hit_c;
    assign bus.fwd_data = fwd_data_c;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - self-checking bench for reg_wb_arbiter
// Age-stamped behavioural model compared every cycle, plus directed literal checks and random traffic.

module tb_reg_wb_arbiter;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int SL = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_wb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .STARVE_LIMIT(SL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: holds carry an age key (edge*2, +1 for load) so smaller key = older entry.
    bit          m_av = 0, m_lv = 0;
    logic [AW-1:0] m_aa = '0, m_la = '0;
    logic [DW-1:0] m_ad = '0, m_ld = '0;
    int          m_ak = 0, m_lk = 0;
    int          m_starve = 0;
    bit          m_we = 0;
    logic [AW-1:0] m_wa = '0;
    logic [DW-1:0] m_wd = '0;
    int          cyc = 0;
    int          g;
    bit          ra, rl;

    function automatic int m_grant();
        if (m_av && !m_lv) return 1;
        if (m_lv && !m_av) return 2;
        if (!m_av) return 0;
        if (m_aa == m_la) return (m_ak < m_lk) ? 1 : 2;
        return (m_starve >= SL - 1) ? 1 : 2;
    endfunction

    function automatic bit m_ready_a();
        return !rst && (!m_av || m_grant() == 1);
    endfunction

    function automatic bit m_ready_l();
        return !rst && (!m_lv || m_grant() == 2);
    endfunction

    function automatic void m_fwd(input logic [AW-1:0] a, output bit hit, output logic [DW-1:0] d);
        int best;
        best = -1;
        hit  = 0;
        d    = '0;
        if (rst || a == '0) return;
        if (m_av && m_aa == a && m_ak > best) begin best = m_ak; d = m_ad; hit = 1; end
        if (m_lv && m_la == a && m_lk > best) begin best = m_lk; d = m_ld; hit = 1; end
        if (!hit && m_we && m_wa == a) begin hit = 1; d = m_wd; end
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_av = 0; m_lv = 0; m_starve = 0;
            m_we = 0; m_wa = '0; m_wd = '0;
        end else begin
            g  = m_grant();
            ra = m_ready_a();
            rl = m_ready_l();
            m_we = (g != 0);
            if (g == 1) begin m_wa = m_aa; m_wd = m_ad; end
            if (g == 2) begin m_wa = m_la; m_wd = m_ld; end
            if (m_av && g != 1) m_starve = (m_starve + 1 > SL - 1) ? SL - 1 : m_starve + 1;
            else                m_starve = 0;
            if (g == 1) m_av = 0;
            if (g == 2) m_lv = 0;
            if (bus.alu_valid && ra && bus.alu_addr != '0) begin
                m_av = 1; m_aa = bus.alu_addr; m_ad = bus.alu_data; m_ak = cyc * 2;
            end
            if (bus.ld_valid && rl && bus.ld_addr != '0) begin
                m_lv = 1; m_la = bus.ld_addr; m_ld = bus.ld_data; m_lk = cyc * 2 + 1;
            end
            cyc++;
        end
    end

    bit          e_hit;
    logic [DW-1:0] e_fd;

    always @(negedge clk) begin
        m_fwd(bus.fwd_addr, e_hit, e_fd);
        chk("alu_ready", 64'(bus.alu_ready), 64'(m_ready_a()));
        chk("ld_ready",  64'(bus.ld_ready),  64'(m_ready_l()));
        chk("wb_we",     64'(bus.wb_we),     64'(m_we));
        chk("wb_addr",   64'(bus.wb_addr),   64'(m_wa));
        chk("wb_data",   64'(bus.wb_data),   64'(m_wd));
        chk("fwd_hit",   64'(bus.fwd_hit),   64'(e_hit));
        chk("fwd_data",  64'(bus.fwd_data),  64'(e_fd));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alu_valid = 0;
        bus.ld_valid  = 0;
    endtask

    task automatic lit_wb(input string name, input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        chk({name, "_we"}, 64'(bus.wb_we), 64'(we));
        if (we) begin
            chk({name, "_addr"}, 64'(bus.wb_addr), 64'(a));
            chk({name, "_data"}, 64'(bus.wb_data), 64'(d));
        end
    endtask

    bit acc;
    int ln;

    initial begin
        rst = 1'b1;
        bus.alu_valid = 0; bus.alu_addr = '0; bus.alu_data = '0;
        bus.ld_valid  = 0; bus.ld_addr  = '0; bus.ld_data  = '0;
        bus.fwd_addr  = '0;
        tick();
        @(negedge clk);
        chk("rst_we", 64'(bus.wb_we), 64'(0));
        chk("rst_alu_ready", 64'(bus.alu_ready), 64'(0));
        chk("rst_ld_ready", 64'(bus.ld_ready), 64'(0));
        chk("rst_fwd_hit", 64'(bus.fwd_hit), 64'(0));
        tick();
        rst = 1'b0;

        // single ALU write
        bus.alu_valid = 1; bus.alu_addr = 3; bus.alu_data = 32'hDEADBEEF;
        tick();
        idle();
        lit_wb("t1_wait", 0, 0, 0);
        tick();
        lit_wb("t1_write", 1, 3, 32'hDEADBEEF);
        tick();
        lit_wb("t1_after", 0, 0, 0);

        // same-edge ALU and load, different registers
        tick();
        bus.alu_valid = 1; bus.alu_addr = 5; bus.alu_data = 32'h11;
        bus.ld_valid  = 1; bus.ld_addr  = 6; bus.ld_data  = 32'h22;
        tick();
        idle();
        @(negedge clk);
        chk("t2_alu_ready_low", 64'(bus.alu_ready), 64'(0));
        tick();
        lit_wb("t2_first", 1, 6, 32'h22);
        tick();
        lit_wb("t2_second", 1, 5, 32'h11);
        tick();
        lit_wb("t2_done", 0, 0, 0);

        // starvation: ALU r2 against a load stream
        tick();
        bus.alu_valid = 1; bus.alu_addr = 2; bus.alu_data = 32'hA2;
        bus.ld_valid  = 1; bus.ld_addr  = 7; bus.ld_data  = 32'h107;
        ln = 7;
        tick();
        bus.alu_valid = 0;
        ln = 8; bus.ld_addr = AW'(ln); bus.ld_data = 32'h100 + ln;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("t3_ld_ready_c%0d", k), 64'(bus.ld_ready), 64'(k != 4));
            if (k == 5) begin
                chk("t3_alu_we", 64'(bus.wb_we), 64'(1));
                chk("t3_alu_addr", 64'(bus.wb_addr), 64'(2));
                chk("t3_alu_data", 64'(bus.wb_data), 64'(32'hA2));
            end
            acc = bus.ld_ready;
            tick();
            if (acc) begin
                ln++;
                bus.ld_addr = AW'(ln);
                bus.ld_data = 32'h100 + ln;
            end
        end
        idle();
        repeat (6) tick();

        // same register from both producers, load younger
        bus.alu_valid = 1; bus.alu_addr = 9;  bus.alu_data = 32'h1;
        bus.ld_valid  = 1; bus.ld_addr  = 20; bus.ld_data  = 32'h20;
        tick();
        bus.alu_valid = 0;
        bus.ld_addr = 9; bus.ld_data = 32'h2;
        tick();
        bus.ld_valid = 0;
        bus.fwd_addr = 9;
        @(negedge clk);
        chk("t4_fwd_hit", 64'(bus.fwd_hit), 64'(1));
        chk("t4_fwd_data", 64'(bus.fwd_data), 64'(32'h2));
        tick();
        lit_wb("t4_first", 1, 9, 32'h1);
        tick();
        lit_wb("t4_second", 1, 9, 32'h2);
        chk("t4_fwd_out", 64'(bus.fwd_data), 64'(32'h2));
        tick();
        bus.fwd_addr = 0;

        // register 0 write
        bus.alu_valid = 1; bus.alu_addr = 0; bus.alu_data = 32'hFFFF;
        @(negedge clk);
        chk("t5_ready", 64'(bus.alu_ready), 64'(1));
        tick();
        idle();
        @(negedge clk);
        chk("t5_fwd_hit", 64'(bus.fwd_hit), 64'(0));
        chk("t5_hold_empty", 64'(bus.alu_ready), 64'(1));
        tick();
        lit_wb("t5_no_write", 0, 0, 0);

        // reset with both holds full
        tick();
        bus.alu_valid = 1; bus.alu_addr = 3;  bus.alu_data = 32'h33;
        bus.ld_valid  = 1; bus.ld_addr  = 4;  bus.ld_data  = 32'h44;
        tick();
        bus.alu_addr = 12; bus.alu_data = 32'hC;
        bus.ld_addr  = 13; bus.ld_data  = 32'hD;
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("t6_we_drop", 64'(bus.wb_we), 64'(0));
        chk("t6_alu_ready", 64'(bus.alu_ready), 64'(0));
        chk("t6_ld_ready", 64'(bus.ld_ready), 64'(0));
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_alu_ready_back", 64'(bus.alu_ready), 64'(1));
        chk("t6_ld_ready_back", 64'(bus.ld_ready), 64'(1));
        tick();
        lit_wb("t6_no_stale1", 0, 0, 0);
        tick();
        lit_wb("t6_no_stale2", 0, 0, 0);

        // random traffic with small address range for collisions and r0
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 499) == 0) rst = 1'b1;
            bus.alu_valid = ($urandom_range(0, 2) != 0);
            bus.alu_addr  = AW'($urandom_range(0, 7));
            bus.alu_data  = $urandom;
            bus.ld_valid  = ($urandom_range(0, 2) != 0);
            bus.ld_addr   = AW'($urandom_range(0, 7));
            bus.ld_data   = $urandom;
            bus.fwd_addr  = AW'($urandom_range(0, 7));
        end
        rst = 1'b0;
        idle();
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
